// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB word-addressed memory slave with wait states, byte strobes and range errors
// Ports:
//   pclk, preset              clock; synchronous active-high reset
//   psel, penable, pwrite     transfer select, access phase, direction (1 = write)
//   paddr, pstrb, pwdata      word address, byte-lane enables, write data
//   prdata, pready, pslverr   read data, completion strobe, error response (both qualified by pready)

package apb_mem_slave_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;
endpackage

module apb_mem_slave
  import apb_mem_slave_pkg::*;
#(
  parameter int  ADDR_WIDTH  = 10,
  parameter int  DATA_WIDTH  = 32,
  parameter int  DEPTH       = 1024,
  parameter int  WAIT_STATES = 0,
  localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [STRB_WIDTH-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WS_INIT = 4'(WAIT_STATES);

  apb_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  addr_ok;
  logic                  done;
  logic                  commit;

  assign addr_ok = ({1'b0, paddr} < DEPTH_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WS_INIT;
      end
      ACCESS: begin
        if (!psel) begin
          // Master withdrew before completion: drop the transfer silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          done = 1'b1;
          // penable low on the completion edge signals a back-to-back transfer.
          state_d = penable ? IDLE : SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == SETUP) begin
        err_q   <= ~addr_ok;
        rdata_q <= addr_ok ? mem[paddr] : '0;
      end
    end
  end

  // Write address is resampled at completion, so it is range-checked again here
  // to keep a moving paddr from indexing past the array.
  assign commit = done & pwrite & ~err_q & addr_ok & ~preset;

  always_ff @(posedge pclk) begin
    if (commit) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (pstrb[i]) mem[paddr][8*i +: 8] <= pwdata[8*i +: 8];
      end
    end
  end

  assign pready  = done;
  assign pslverr = done & err_q;
  assign prdata  = done ? rdata_q : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - self-checking bench for apb_mem_slave (three parameterisations)
module tb_apb_mem_slave;

  logic              pclk = 1'b0;
  logic              preset;
  logic              penable;
  logic              pwrite;
  logic [2:0]        psel_v;
  logic [9:0]        paddr;
  logic [3:0]        pstrb;
  logic [31:0]       pwdata;
  logic [2:0][31:0]  prdata_v;
  logic [2:0]        pready_v;
  logic [2:0]        pslverr_v;

  int checks = 0;
  int errors = 0;

  int ws_p    [3] = '{0, 2, 3};
  int depth_p [3] = '{1000, 1024, 1024};
  logic [31:0] ref_mem [3][1024];

  always #5 pclk = ~pclk;

  apb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(1000), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0])
  );

  apb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(2)) dut1 (
    .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1])
  );

  apb_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) dut2 (
    .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Called #1 after an edge. b2b_in: slave already in SETUP from a previous back-to-back
  // completion. keep: hold psel and drop penable at completion to chain the next transfer.
  task automatic xfer(input int d, input bit wr, input logic [9:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit b2b_in, input bit keep, input string tag,
                      output logic [31:0] rd, output logic err);
    int   n;
    bit   got;
    bit   exp_err;
    int   exp_lat;
    logic [31:0] exp_rd;
    exp_err = (int'(a) >= depth_p[d]);
    exp_rd  = exp_err ? 32'h0 : ref_mem[d][a];
    exp_lat = ws_p[d] + (b2b_in ? 1 : 2);
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    psel_v[d] = 1'b1;
    penable = 1'b0;
    n = 0; got = 0;
    rd = 32'h0; err = 1'b0;
    while (!got && n < 64) begin
      @(posedge pclk); #1;
      n++;
      penable = 1'b1;
      if (pready_v[d]) begin
        got = 1;
      end else begin
        check({tag, "/wait_pslverr"}, 32'(pslverr_v[d]), 32'h0);
        check({tag, "/wait_prdata"}, prdata_v[d], 32'h0);
      end
    end
    check({tag, "/latency"}, n, exp_lat);
    if (got) begin
      rd  = prdata_v[d];
      err = pslverr_v[d];
      check({tag, "/pslverr"}, 32'(err), 32'(exp_err));
      if (!wr) check({tag, "/prdata"}, rd, exp_rd);
    end
    penable = keep ? 1'b0 : 1'b1;
    @(posedge pclk); #1;
    if (got && wr && !exp_err) ref_mem[d][a] = merge(ref_mem[d][a], wd, st);
    if (!keep) begin
      psel_v[d] = 1'b0;
      penable = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [9:0]  a;
    logic [3:0]  st;
    bit          wr, keep, prev_keep;

    preset = 1'b1; psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pstrb = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("reset/pready", 32'(pready_v[d]), 32'h0);
      check("reset/pslverr", 32'(pslverr_v[d]), 32'h0);
      check("reset/prdata", prdata_v[d], 32'h0);
    end
    preset = 1'b0;
    @(posedge pclk); #1;

    // Zero wait states: write/read, then a zero-strobe write is a no-op.
    xfer(0, 1, 10'h005, 32'hDEADBEEF, 4'hF, 0, 0, "ws0_wr", rd, err);
    xfer(0, 0, 10'h005, 32'h0, 4'h0, 0, 0, "ws0_rd", rd, err);
    check("ws0_rd/const", rd, 32'hDEADBEEF);
    xfer(0, 1, 10'h005, 32'h12345678, 4'h0, 0, 0, "strb0_wr", rd, err);
    check("strb0_wr/err", 32'(err), 32'h0);
    xfer(0, 0, 10'h005, 32'h0, 4'h0, 0, 0, "strb0_rd", rd, err);
    check("strb0_rd/const", rd, 32'hDEADBEEF);

    // Partial byte strobes.
    xfer(0, 1, 10'h010, 32'h11223344, 4'hF, 0, 0, "strb_wr1", rd, err);
    xfer(0, 1, 10'h010, 32'hAABBCCDD, 4'b0101, 0, 0, "strb_wr2", rd, err);
    xfer(0, 0, 10'h010, 32'h0, 4'h0, 0, 0, "strb_rd", rd, err);
    check("strb_rd/const", rd, 32'h11BB33DD);

    // Range boundary on the DEPTH=1000 instance.
    xfer(0, 1, 10'd999, 32'h55AA55AA, 4'hF, 0, 0, "oor_wr999", rd, err);
    xfer(0, 1, 10'd1000, 32'h12345678, 4'hF, 0, 0, "oor_wr1000", rd, err);
    check("oor_wr1000/err", 32'(err), 32'h1);
    xfer(0, 0, 10'd1000, 32'h0, 4'h0, 0, 0, "oor_rd1000", rd, err);
    check("oor_rd1000/err", 32'(err), 32'h1);
    check("oor_rd1000/data", rd, 32'h0);
    xfer(0, 0, 10'd999, 32'h0, 4'h0, 0, 0, "oor_rd999", rd, err);
    check("oor_rd999/const", rd, 32'h55AA55AA);

    // Back-to-back writes with psel held high.
    xfer(0, 1, 10'h040, 32'hA5A50001, 4'hF, 0, 1, "b2b_wr1", rd, err);
    xfer(0, 1, 10'h041, 32'h5A5A0002, 4'hF, 1, 0, "b2b_wr2", rd, err);
    xfer(0, 0, 10'h040, 32'h0, 4'h0, 0, 0, "b2b_rd1", rd, err);
    check("b2b_rd1/const", rd, 32'hA5A50001);
    xfer(0, 0, 10'h041, 32'h0, 4'h0, 0, 0, "b2b_rd2", rd, err);
    check("b2b_rd2/const", rd, 32'h5A5A0002);

    // Three wait states.
    xfer(2, 1, 10'h050, 32'h0F0F1234, 4'hF, 0, 0, "ws3_wr", rd, err);
    xfer(2, 0, 10'h050, 32'h0, 4'h0, 0, 0, "ws3_rd", rd, err);
    check("ws3_rd/const", rd, 32'h0F0F1234);

    // Reset in the second ACCESS cycle of a two-wait-state write.
    xfer(1, 1, 10'h020, 32'h0BADC0DE, 4'hF, 0, 0, "rst_pre", rd, err);
    psel_v[1] = 1'b1; pwrite = 1'b1; paddr = 10'h020; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check("rst_mid/pready", 32'(pready_v[1]), 32'h0);
    preset = 1'b1;
    @(posedge pclk); #1;
    check("rst_after/pready", 32'(pready_v[1]), 32'h0);
    check("rst_after/pslverr", 32'(pslverr_v[1]), 32'h0);
    check("rst_after/prdata", prdata_v[1], 32'h0);
    preset = 1'b0; psel_v[1] = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    check("rst_idle/pready", 32'(pready_v[1]), 32'h0);
    xfer(1, 0, 10'h020, 32'h0, 4'h0, 0, 0, "rst_rd", rd, err);
    check("rst_rd/const", rd, 32'h0BADC0DE);

    // psel withdrawn mid-ACCESS aborts without writing.
    xfer(2, 1, 10'h030, 32'h13579BDF, 4'hF, 0, 0, "abort_pre", rd, err);
    psel_v[2] = 1'b1; pwrite = 1'b1; paddr = 10'h030; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_v[2] = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      check("abort/pready", 32'(pready_v[2]), 32'h0);
    end
    xfer(2, 0, 10'h030, 32'h0, 4'h0, 0, 0, "abort_rd", rd, err);
    check("abort_rd/const", rd, 32'h13579BDF);

    // Randomised traffic against the reference memory.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 32; k++) begin
        xfer(d, 1, 10'(k), 32'($urandom), 4'hF, 0, 0, "rand_init", rd, err);
      end
      prev_keep = 0;
      for (int k = 0; k < 40; k++) begin
        wr = ($urandom_range(0, 1) == 1);
        a  = 10'($urandom_range(0, 31));
        if (d == 0 && $urandom_range(0, 7) == 0) a = 10'($urandom_range(1000, 1023));
        st = 4'($urandom_range(0, 15));
        keep = (k != 39) && ($urandom_range(0, 1) == 1);
        xfer(d, wr, a, 32'($urandom), st, prev_keep, keep, "rand", rd, err);
        prev_keep = keep;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
